// File: rtl/operand_fetch_stage_pkg.sv
// Shared register-file constants used by decode, operand fetch and the regfile.
package operand_fetch_stage_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

   localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_fetch_stage_register_scoreboard.sv
// Pending-write scoreboard; every query already discounts this cycle's writeback.
module register_scoreboard
   import operand_fetch_stage_pkg::*;
#(
   parameter int ADDR_W = operand_fetch_stage_pkg::REG_ADDR_WIDTH,
   parameter int NUM    = operand_fetch_stage_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set,
   input  logic [ADDR_W-1:0] set_index,
   input  logic              clear,
   input  logic [ADDR_W-1:0] clear_index,
   input  logic [ADDR_W-1:0] query_a,
   input  logic [ADDR_W-1:0] query_b,
   input  logic [ADDR_W-1:0] query_d,
   output logic              busy_a,
   output logic              busy_b,
   output logic              busy_d
);

   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic [NUM-1:0] pending;
   logic [NUM-1:0] pending_next;

   function automatic logic busy(input logic [ADDR_W-1:0] idx);
      return idx != ZERO && pending[idx] && !(clear && clear_index == idx);
   endfunction

   assign busy_a = busy(query_a);
   assign busy_b = busy(query_b);
   assign busy_d = busy(query_d);

   // Set is applied after clear so a same-register issue survives writeback.
   always_comb begin
      pending_next = pending;
      if (clear) pending_next[clear_index] = 1'b0;
      if (set)   pending_next[set_index]   = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) pending <= '0;
      else       pending <= pending_next;
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-file read stage: writeback bypass, hazard stall and one output register.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = operand_fetch_stage_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = operand_fetch_stage_pkg::REG_ADDR_WIDTH,
   parameter int NUM_REGS       = 2 ** REG_ADDR_WIDTH
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      InValid,
   output logic                      InReady,
   input  logic [REG_ADDR_WIDTH-1:0] InSrcA,
   input  logic [REG_ADDR_WIDTH-1:0] InSrcB,
   input  logic [REG_ADDR_WIDTH-1:0] InDest,
   input  logic                      InWritesDest,
   output logic [REG_ADDR_WIDTH-1:0] ReadSourceA,
   output logic [REG_ADDR_WIDTH-1:0] ReadSourceB,
   input  logic [DATA_WIDTH-1:0]     ReadPortA,
   input  logic [DATA_WIDTH-1:0]     ReadPortB,
   input  logic                      WbEnable,
   input  logic [REG_ADDR_WIDTH-1:0] WbTarget,
   input  logic [DATA_WIDTH-1:0]     WbData,
   output logic                      OutValid,
   input  logic                      OutReady,
   output logic [DATA_WIDTH-1:0]     OutOperandA,
   output logic [DATA_WIDTH-1:0]     OutOperandB,
   output logic [REG_ADDR_WIDTH-1:0] OutDest,
   output logic                      OutWritesDest
);

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO = REG_ADDR_WIDTH'(REG_ZERO);

   logic busy_a;
   logic busy_b;
   logic busy_d;
   logic hazard;
   logic accept;
   logic [DATA_WIDTH-1:0] operand_a;
   logic [DATA_WIDTH-1:0] operand_b;

   assign ReadSourceA = InSrcA;
   assign ReadSourceB = InSrcB;

   register_scoreboard #(
      .ADDR_W (REG_ADDR_WIDTH),
      .NUM    (NUM_REGS)
   ) u_scoreboard (
      .clk         (Clock),
      .reset       (Reset),
      .set         (accept && InWritesDest && InDest != ZERO),
      .set_index   (InDest),
      .clear       (WbEnable && WbTarget != ZERO),
      .clear_index (WbTarget),
      .query_a     (InSrcA),
      .query_b     (InSrcB),
      .query_d     (InDest),
      .busy_a      (busy_a),
      .busy_b      (busy_b),
      .busy_d      (busy_d)
   );

   assign hazard  = busy_a || busy_b || (InWritesDest && busy_d);
   assign InReady = !hazard && (!OutValid || OutReady);
   assign accept  = InValid && InReady;

   // The regfile write is registered, so same-cycle writeback must be bypassed.
   always_comb begin
      operand_a = ReadPortA;
      operand_b = ReadPortB;
      if (WbEnable && WbTarget == InSrcA) operand_a = WbData;
      if (WbEnable && WbTarget == InSrcB) operand_b = WbData;
      if (InSrcA == ZERO) operand_a = '0;
      if (InSrcB == ZERO) operand_b = '0;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         OutValid      <= 1'b0;
         OutOperandA   <= '0;
         OutOperandB   <= '0;
         OutDest       <= '0;
         OutWritesDest <= 1'b0;
      end else if (accept) begin
         OutValid      <= 1'b1;
         OutOperandA   <= operand_a;
         OutOperandB   <= operand_b;
         OutDest       <= InDest;
         OutWritesDest <= InWritesDest;
      end else if (OutReady) begin
         OutValid      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Randomized bench for operand_fetch_stage against a pending-set/regfile model.
module tb_operand_fetch_stage;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InSrcA;
   logic [4:0]  InSrcB;
   logic [4:0]  InDest;
   logic        InWritesDest;
   logic [4:0]  ReadSourceA;
   logic [4:0]  ReadSourceB;
   logic [31:0] ReadPortA;
   logic [31:0] ReadPortB;
   logic        WbEnable;
   logic [4:0]  WbTarget;
   logic [31:0] WbData;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutOperandA;
   logic [31:0] OutOperandB;
   logic [4:0]  OutDest;
   logic        OutWritesDest;

   int total = 0;
   int bad   = 0;

   logic [31:0] rf [32];
   bit          pend [32];
   bit          m_ov;
   logic [31:0] m_oa;
   logic [31:0] m_ob;
   logic [4:0]  m_od;
   bit          m_ow;
   bit          seen_ready;

   always #5 Clock = ~Clock;

   assign ReadPortA = rf[ReadSourceA];
   assign ReadPortB = rf[ReadSourceB];

   operand_fetch_stage dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .InValid       (InValid),
      .InReady       (InReady),
      .InSrcA        (InSrcA),
      .InSrcB        (InSrcB),
      .InDest        (InDest),
      .InWritesDest  (InWritesDest),
      .ReadSourceA   (ReadSourceA),
      .ReadSourceB   (ReadSourceB),
      .ReadPortA     (ReadPortA),
      .ReadPortB     (ReadPortB),
      .WbEnable      (WbEnable),
      .WbTarget      (WbTarget),
      .WbData        (WbData),
      .OutValid      (OutValid),
      .OutReady      (OutReady),
      .OutOperandA   (OutOperandA),
      .OutOperandB   (OutOperandB),
      .OutDest       (OutDest),
      .OutWritesDest (OutWritesDest)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] resolve(input logic [4:0] src, input bit wbe,
                                           input logic [4:0] wbt,
                                           input logic [31:0] wbd);
      if (src == 0) return 32'd0;
      if (wbe && wbt == src) return wbd;
      return rf[src];
   endfunction

   function automatic bit waits_on(input logic [4:0] r, input bit wbe,
                                   input logic [4:0] wbt);
      return r != 0 && pend[r] && !(wbe && wbt == r);
   endfunction

   task automatic step(input bit rst, input bit v, input logic [4:0] sa,
                       input logic [4:0] sb, input logic [4:0] d, input bit wd,
                       input bit ordy, input bit wbe, input logic [4:0] wbt,
                       input logic [31:0] wbd);
      bit rdy;
      bit acc;
      logic [31:0] oa;
      logic [31:0] ob;
      @(negedge Clock);
      Reset = rst; InValid = v; InSrcA = sa; InSrcB = sb; InDest = d;
      InWritesDest = wd; OutReady = ordy; WbEnable = wbe; WbTarget = wbt;
      WbData = wbd;
      #1;
      rdy = !(waits_on(sa, wbe, wbt) || waits_on(sb, wbe, wbt) ||
              (wd && waits_on(d, wbe, wbt))) && (!m_ov || ordy);
      acc = v && rdy && !rst;
      oa = resolve(sa, wbe, wbt, wbd);
      ob = resolve(sb, wbe, wbt, wbd);
      seen_ready = InReady;
      check("in_ready", {63'd0, InReady}, {63'd0, rdy});
      check("rd_src", {54'd0, ReadSourceA, ReadSourceB}, {54'd0, sa, sb});
      @(posedge Clock);
      #1;
      if (wbe) rf[wbt] = wbd;
      if (rst) begin
         foreach (pend[i]) pend[i] = 0;
         m_ov = 0; m_oa = 0; m_ob = 0; m_od = 0; m_ow = 0;
      end else begin
         if (wbe) pend[wbt] = 0;
         if (acc && wd && d != 0) pend[d] = 1;
         if (acc) begin
            m_ov = 1; m_oa = oa; m_ob = ob; m_od = d; m_ow = wd;
         end else if (ordy) begin
            m_ov = 0;
         end
      end
      check("out_valid", {63'd0, OutValid}, {63'd0, m_ov});
      check("out_a", {32'd0, OutOperandA}, {32'd0, m_oa});
      check("out_b", {32'd0, OutOperandB}, {32'd0, m_ob});
      check("out_dest", {58'd0, OutDest, OutWritesDest}, {58'd0, m_od, m_ow});
   endtask

   initial begin
      logic [31:0] held;
      logic [4:0]  cand [$];
      logic [4:0]  wt;
      foreach (rf[i]) rf[i] = $urandom;
      foreach (pend[i]) pend[i] = 0;
      m_ov = 0; m_oa = 0; m_ob = 0; m_od = 0; m_ow = 0;
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      check("reset_valid", {63'd0, OutValid}, 64'd0);

      // pending r3 is wiped by reset
      step(0, 1, 0, 0, 3, 1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_drop", {63'd0, OutValid}, 64'd0);
      step(0, 1, 3, 0, 0, 0, 1, 0, 0, 0);
      check("post_rst_ready", {63'd0, seen_ready}, 64'd1);

      // RAW stall released by writeback bypass
      step(0, 1, 0, 0, 5, 1, 1, 0, 0, 0);
      step(0, 1, 5, 0, 0, 0, 1, 0, 0, 0);
      check("raw_stall", {63'd0, seen_ready}, 64'd0);
      step(0, 1, 5, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF);
      check("raw_release", {63'd0, seen_ready}, 64'd1);
      check("bypass_a", {32'd0, OutOperandA}, 64'hDEADBEEF);

      // r0 reads zero and is never scoreboarded
      rf[0] = 32'h1234;
      step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
      check("zero_b", {32'd0, OutOperandB}, 64'd0);
      step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      check("r0_free", {63'd0, seen_ready}, 64'd1);

      // backpressure holds outputs
      step(0, 1, 1, 2, 4, 0, 0, 0, 0, 0);
      held = OutOperandA;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 6, 2, 1, 0, 0, 0, 0, 0);
         check("hold_ready", {63'd0, seen_ready}, 64'd0);
         check("hold_a", {32'd0, OutOperandA}, {32'd0, held});
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 5'(i + 1), 2, 0, 0, 1, 0, 0, 0);
         check("b2b_ready", {63'd0, seen_ready}, 64'd1);
         check("b2b_valid", {63'd0, OutValid}, 64'd1);
      end

      // set wins over same-cycle clear on r7
      step(0, 1, 0, 0, 7, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 7, 1, 1, 1, 7, 32'h77);
      check("waw_clear", {63'd0, seen_ready}, 64'd1);
      step(0, 1, 7, 0, 0, 0, 1, 0, 0, 0);
      check("set_wins", {63'd0, seen_ready}, 64'd0);

      // reset during a held output
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_hold_valid", {63'd0, OutValid}, 64'd0);
      step(0, 1, 7, 0, 0, 0, 1, 0, 0, 0);
      check("rst_sb_clear", {63'd0, seen_ready}, 64'd1);

      for (int n = 0; n < 2000; n++) begin
         cand.delete();
         for (int r = 1; r < 8; r++) if (pend[r]) cand.push_back(5'(r));
         if (cand.size() > 0 && $urandom_range(0, 4) != 0)
            wt = cand[$urandom_range(0, cand.size() - 1)];
         else
            wt = 5'($urandom_range(0, 7));
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom),
              $urandom_range(0, 3) != 0, 1'($urandom), wt, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
